// File: rtl/pid_pkg.sv
// Shared types and constants for the time-multiplexed PID MAC sequencer.
package pid_pkg;

  localparam int ERR_W  = 10;
  localparam int GAIN_W = 10;
  localparam int OUT_W  = 19;
  localparam int ACC_W  = 23;
  localparam int DIFF_W = ERR_W + 1;
  localparam int PE_W   = GAIN_W + ERR_W;
  localparam int PROD_W = GAIN_W + DIFF_W;

  localparam logic signed [OUT_W-1:0] INT_MAX_DEF   = 19'sh3FFFE;
  localparam int                      INT_SHIFT_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    MUL_P,
    MUL_I,
    MUL_D,
    SUM
  } state_e;

  typedef enum logic [1:0] {
    SEL_KP   = 2'd0,
    SEL_KI   = 2'd1,
    SEL_KD   = 2'd2,
    SEL_NONE = 2'd3
  } cfg_sel_e;

endpackage

// File: rtl/pid_mac_sequencer_if.sv
// Sample, integrator-control and gain-config signals between the error stage, controller and DPWM.
interface pid_mac_sequencer_if;
  import pid_pkg::*;

  logic                     start;
  logic signed [ERR_W-1:0]  N_er;
  logic                     int_hold;
  logic                     int_clr;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [1:0]               cfg_sel;
  logic signed [GAIN_W-1:0] cfg_data;
  logic signed [OUT_W-1:0]  N_con;
  logic                     done;
  logic                     busy;
  logic                     sat;
  logic                     overrun;
  logic                     clr_ovr;

  modport master (
    output start, N_er, int_hold, int_clr, cfg_valid, cfg_sel, cfg_data, clr_ovr,
    input  cfg_ready, N_con, done, busy, sat, overrun
  );

  modport slave (
    input  start, N_er, int_hold, int_clr, cfg_valid, cfg_sel, cfg_data, clr_ovr,
    output cfg_ready, N_con, done, busy, sat, overrun
  );
endinterface

// File: rtl/pid_sat.sv
// Signed saturator: clips i_val into [MIN_VAL, MAX_VAL] and flags when clipping happened.
module pid_sat #(
  parameter int IN_W    = 23,
  parameter int OUT_W   = 19,
  parameter int MAX_VAL = (2 ** (OUT_W - 1)) - 1,
  parameter int MIN_VAL = -(2 ** (OUT_W - 1))
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_val,
  output logic                    o_clip
);
  localparam logic signed [IN_W-1:0] L_MAX = IN_W'(MAX_VAL);
  localparam logic signed [IN_W-1:0] L_MIN = IN_W'(MIN_VAL);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_val  = i_val[OUT_W-1:0];
    o_clip = 1'b0;
    if (i_val > L_MAX) begin
      o_val  = L_MAX[OUT_W-1:0];
      o_clip = 1'b1;
    end else if (i_val < L_MIN) begin
      o_val  = L_MIN[OUT_W-1:0];
      o_clip = 1'b1;
    end
  end
endmodule

// File: rtl/pid_mac_sequencer.sv
// PID engine: one shared signed 10x11 multiplier stepped through P, I and D per start pulse,
// with gain registers, clamped integrator and saturated 19-bit output.
module pid_mac_sequencer
  import pid_pkg::*;
#(
  parameter logic signed [OUT_W-1:0] INT_MAX   = INT_MAX_DEF,
  parameter int                      INT_SHIFT = INT_SHIFT_DEF
) (
  input logic                f_pwm,
  input logic                rst,
  pid_mac_sequencer_if.slave bus
);

  state_e r_state, w_state_next;

  logic signed [GAIN_W-1:0] r_kp, r_ki, r_kd;
  logic signed [GAIN_W-1:0] r_kp_s, r_ki_s, r_kd_s;
  logic signed [ERR_W-1:0]  r_e, r_e_prev;
  logic signed [PE_W-1:0]   r_p, r_kie;
  logic signed [PROD_W-1:0] r_d;
  logic signed [OUT_W-1:0]  r_acc, r_n_con;
  logic                     r_sat, r_done, r_overrun;

  logic signed [GAIN_W-1:0] w_mul_a;
  logic signed [DIFF_W-1:0] w_mul_b, w_e_ext, w_eprev_ext, w_diff;
  logic signed [PROD_W-1:0] w_prod, w_acc_ext, w_kie_ext, w_kie_sh, w_acc_sum;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [OUT_W-1:0]  w_acc_clamped, w_sum_sat;
  logic                     w_acc_clip, w_sum_clip, w_idle, w_start_acc, w_cfg_wr;

  assign w_idle      = (r_state == IDLE);
  assign w_start_acc = w_idle && bus.start;
  assign w_cfg_wr    = w_idle && bus.cfg_valid;

  always_comb begin
    w_state_next = r_state;
    w_mul_a      = '0;
    w_mul_b      = '0;
    case (r_state)
      IDLE:  if (bus.start) w_state_next = MUL_P;
      MUL_P: begin w_state_next = MUL_I; w_mul_a = r_kp_s; w_mul_b = w_e_ext; end
      MUL_I: begin w_state_next = MUL_D; w_mul_a = r_ki_s; w_mul_b = w_e_ext; end
      MUL_D: begin w_state_next = SUM;   w_mul_a = r_kd_s; w_mul_b = w_diff;  end
      SUM:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Single shared multiplier; operands sign-extend to the full product width.
  assign w_e_ext     = {r_e[ERR_W-1], r_e};
  assign w_eprev_ext = {r_e_prev[ERR_W-1], r_e_prev};
  assign w_diff      = w_e_ext - w_eprev_ext;
  assign w_prod      = PROD_W'(w_mul_a) * PROD_W'(w_mul_b);

  assign w_acc_ext = {{(PROD_W-OUT_W){r_acc[OUT_W-1]}}, r_acc};
  assign w_kie_ext = {r_kie[PE_W-1], r_kie};
  assign w_kie_sh  = w_kie_ext >>> INT_SHIFT;
  assign w_acc_sum = w_acc_ext + w_kie_sh;

  assign w_sum = {{(ACC_W-PE_W){r_p[PE_W-1]}}, r_p}
               + {{(ACC_W-OUT_W){r_acc[OUT_W-1]}}, r_acc}
               + {{(ACC_W-PROD_W){r_d[PROD_W-1]}}, r_d};

  pid_sat #(.IN_W(PROD_W), .OUT_W(OUT_W), .MAX_VAL(int'(INT_MAX)), .MIN_VAL(-int'(INT_MAX)))
    u_acc_sat (.i_val(w_acc_sum), .o_val(w_acc_clamped), .o_clip(w_acc_clip));

  pid_sat #(.IN_W(ACC_W), .OUT_W(OUT_W))
    u_out_sat (.i_val(w_sum), .o_val(w_sum_sat), .o_clip(w_sum_clip));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge f_pwm or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge f_pwm or posedge rst) begin
    if (rst) begin
      r_kp <= '0; r_ki <= '0; r_kd <= '0;
      r_kp_s <= '0; r_ki_s <= '0; r_kd_s <= '0;
      r_e <= '0; r_e_prev <= '0; r_acc <= '0;
      r_p <= '0; r_kie <= '0; r_d <= '0;
      r_n_con <= '0; r_sat <= 1'b0; r_done <= 1'b0; r_overrun <= 1'b0;
    end else begin
      // Snapshot reads the old gains, so a same-edge config write affects only later samples.
      if (w_start_acc) begin
        r_e    <= bus.N_er;
        r_kp_s <= r_kp;
        r_ki_s <= r_ki;
        r_kd_s <= r_kd;
      end
      if (w_cfg_wr) begin
        case (cfg_sel_e'(bus.cfg_sel))
          SEL_KP:  r_kp <= bus.cfg_data;
          SEL_KI:  r_ki <= bus.cfg_data;
          SEL_KD:  r_kd <= bus.cfg_data;
          default: ;
        endcase
      end
      case (r_state)
        MUL_P: r_p   <= w_prod[PE_W-1:0];
        MUL_I: r_kie <= w_prod[PE_W-1:0];
        MUL_D: r_d   <= w_prod;
        SUM: begin
          r_n_con <= w_sum_sat;
          r_sat   <= w_sum_clip;
        end
        default: ;
      endcase
      if (bus.int_clr) begin
        r_acc    <= '0;
        r_e_prev <= '0;
      end else if (r_state == MUL_D) begin
        if (!bus.int_hold) r_acc <= w_acc_clamped;
        r_e_prev <= r_e;
      end
      r_done <= (r_state == SUM);
      if (bus.start && !w_idle) r_overrun <= 1'b1;
      else if (bus.clr_ovr)     r_overrun <= 1'b0;
    end
  end

  assign bus.cfg_ready = w_idle;
  assign bus.busy      = !w_idle;
  assign bus.N_con     = r_n_con;
  assign bus.done      = r_done;
  assign bus.sat       = r_sat;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_pid_mac_sequencer.sv
// Self-checking bench for pid_mac_sequencer: vector table, hand-written corner sequences and
// randomized samples checked against a per-sample arithmetic model.
module tb_pid_mac_sequencer;
  import pid_pkg::*;

  localparam int INT_LIM = 262142;
  localparam int OUT_MAX = 262143;
  localparam int OUT_MIN = -262144;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pid_mac_sequencer_if bus ();
  pid_mac_sequencer dut (.f_pwm(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  int m_kp, m_ki, m_kd, m_acc, m_eprev;

  typedef struct {
    bit do_rst;
    int kp, ki, kd, e;
    int exp_n;
    bit exp_sat;
  } vec_t;
  vec_t tab[7];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_reset();
    m_kp = 0; m_ki = 0; m_kd = 0; m_acc = 0; m_eprev = 0;
  endtask

  task automatic model_write(input int sel, input int data);
    case (sel)
      0: m_kp = data;
      1: m_ki = data;
      2: m_kd = data;
      default: ;
    endcase
  endtask

  // One whole sample computed directly from the controller equations.
  task automatic model_sample(input int e, input bit hold, output int n, output bit s);
    int p, inc, d, total;
    p   = m_kp * e;
    inc = (m_ki * e) >>> 3;
    if (!hold) m_acc = clampi(m_acc + inc, -INT_LIM, INT_LIM);
    d       = m_kd * (e - m_eprev);
    m_eprev = e;
    total   = p + m_acc + d;
    n       = clampi(total, OUT_MIN, OUT_MAX);
    s       = (n != total);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic write_cfg(input int sel, input int data);
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_sel   = 2'(sel);
    bus.cfg_data  = 10'(data);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    model_write(sel, data);
  endtask

  task automatic set_gains(input int kp, input int ki, input int kd);
    write_cfg(0, kp);
    write_cfg(1, ki);
    write_cfg(2, kd);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.int_clr = 1'b1;
    @(negedge clk);
    bus.int_clr = 1'b0;
    m_acc = 0;
    m_eprev = 0;
  endtask

  // Drives one sample; compares against table values when use_exp is set, else the model.
  task automatic run_sample(input string name, input int e, input bit hold,
                            input bit cfg_en, input int sel, input int data,
                            input bit use_exp, input int tab_n, input bit tab_sat);
    int n, lat;
    bit s;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.N_er     = 10'(e);
    bus.int_hold = hold;
    if (cfg_en) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_sel   = 2'(sel);
      bus.cfg_data  = 10'(data);
    end
    model_sample(e, hold, n, s);
    if (cfg_en) model_write(sel, data);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.cfg_valid = 1'b0;
    lat = 0;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    bus.int_hold = 1'b0;
    check({name, "_latency"}, lat, 4);
    check({name, "_n_con"}, int'(bus.N_con), use_exp ? tab_n : n);
    check({name, "_sat"}, int'(bus.sat), use_exp ? int'(tab_sat) : int'(s));
    @(negedge clk);
    check({name, "_done_pulse"}, int'(bus.done), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.N_er = '0; bus.int_hold = 1'b0; bus.int_clr = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_sel = '0; bus.cfg_data = '0; bus.clr_ovr = 1'b0;
    model_reset();

    tab[0] = '{1'b1,    2,    8,    1,    5,      20, 1'b0};
    tab[1] = '{1'b0,    2,    8,    1,    5,      20, 1'b0};
    tab[2] = '{1'b0,    2,    8,    1,   -3,      -7, 1'b0};
    tab[3] = '{1'b1,  511,  511,  511,  511,  262143, 1'b1};
    tab[4] = '{1'b0, -512, -512, -512, -512,  262143, 1'b1};
    tab[5] = '{1'b1, -512, -512, -512,  511, -262144, 1'b1};
    tab[6] = '{1'b1,    0,    0,    0,  100,       0, 1'b0};

    #12;
    check("rst_n_con", int'(bus.N_con), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cfg_ready", int'(bus.cfg_ready), 1);
    check("rst_done", int'(bus.done), 0);
    check("rst_sat", int'(bus.sat), 0);
    check("rst_overrun", int'(bus.overrun), 0);

    for (int i = 0; i < 7; i++) begin
      if (tab[i].do_rst) apply_reset();
      set_gains(tab[i].kp, tab[i].ki, tab[i].kd);
      run_sample($sformatf("vec%0d", i), tab[i].e, 1'b0, 1'b0, 0, 0, 1'b1, tab[i].exp_n, tab[i].exp_sat);
    end

    // Integrator clamp, int_clr and int_hold.
    apply_reset();
    set_gains(0, 511, 0);
    for (int k = 1; k <= 10; k++)
      run_sample($sformatf("clamp%0d", k), 511, 1'b0, 1'b0, 0, 0, 1'b1,
                 (k * 32640 > INT_LIM) ? INT_LIM : k * 32640, 1'b0);
    pulse_clr();
    run_sample("after_clr", 511, 1'b0, 1'b0, 0, 0, 1'b1, 32640, 1'b0);
    run_sample("hold", 511, 1'b1, 1'b0, 0, 0, 1'b1, 32640, 1'b0);

    // Starts and config requests while busy are refused; set beats clr_ovr.
    apply_reset();
    set_gains(3, 8, 2);
    run_sample("hs_pre", 10, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    begin
      int n;
      bit s;
      @(negedge clk);
      bus.start = 1'b1;
      bus.N_er  = -10'sd20;
      model_sample(-20, 1'b0, n, s);
      @(negedge clk);
      bus.N_er      = 10'sd100;
      bus.cfg_valid = 1'b1;
      bus.cfg_sel   = 2'd0;
      bus.cfg_data  = 10'sd77;
      for (int i = 1; i <= 4; i++) begin
        check($sformatf("hs_busy%0d", i), int'(bus.busy), 1);
        check($sformatf("hs_cfg_ready%0d", i), int'(bus.cfg_ready), 0);
        bus.clr_ovr = (i == 1);
        @(negedge clk);
        if (i == 1) check("hs_ovr_set_wins", int'(bus.overrun), 1);
      end
      bus.start     = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.clr_ovr   = 1'b0;
      check("hs_done", int'(bus.done), 1);
      check("hs_n_con", int'(bus.N_con), n);
      check("hs_overrun", int'(bus.overrun), 1);
    end
    run_sample("hs_post", -20, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    check("hs_ovr_sticky", int'(bus.overrun), 1);
    @(negedge clk);
    bus.clr_ovr = 1'b1;
    @(negedge clk);
    bus.clr_ovr = 1'b0;
    check("hs_ovr_clr", int'(bus.overrun), 0);

    // Config write coincident with start: snapshot keeps the old Kp.
    set_gains(2, 8, 2);
    run_sample("same_edge", 5, 1'b0, 1'b1, 0, 4, 1'b0, 0, 1'b0);
    run_sample("same_edge_next", 5, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);

    // Reset while the multiplier is on the I term.
    set_gains(5, 8, 3);
    run_sample("pre_rst", 9, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.N_er  = -10'sd4;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_n_con", int'(bus.N_con), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_cfg_ready", int'(bus.cfg_ready), 1);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_overrun", int'(bus.overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    model_reset();
    set_gains(0, 0, 3);
    run_sample("post_rst", 7, 1'b0, 1'b0, 0, 0, 1'b1, 21, 1'b0);

    // Randomized samples against the model.
    for (int i = 0; i < 60; i++) begin
      logic signed [9:0] rv;
      if ($urandom_range(0, 2) == 0) begin
        rv = 10'($urandom);
        write_cfg(int'($urandom_range(0, 3)), int'(rv));
      end
      if ($urandom_range(0, 9) == 0) pulse_clr();
      rv = 10'($urandom);
      run_sample($sformatf("rnd%0d", i), int'(rv), ($urandom_range(0, 3) == 0),
                 1'b0, 0, 0, 1'b0, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
